// File: rtl/vga_test_pattern_pkg.sv
// Shared encodings and constants for the VGA test-pattern colour stage.
package vga_test_pattern_pkg;

   // Background pattern select encodings.
   typedef enum logic [1:0] {
      PAT_BLACK = 2'd0,
      PAT_BARS  = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_GRAD  = 2'd3
   } pattern_e;

   // Colours packed as {red[2:0], grn[2:0], blu[2:0]}; one octal digit per channel.
   localparam logic [8:0] COL_BLACK   = 9'o000;
   localparam logic [8:0] COL_WHITE   = 9'o777;
   localparam logic [8:0] COL_YELLOW  = 9'o770;
   localparam logic [8:0] COL_CYAN    = 9'o077;
   localparam logic [8:0] COL_GREEN   = 9'o070;
   localparam logic [8:0] COL_MAGENTA = 9'o707;
   localparam logic [8:0] COL_RED     = 9'o700;
   localparam logic [8:0] COL_BLUE    = 9'o007;

   // Cycles from pixel input to colour output; sync outputs are delayed to match.
   localparam int unsigned PIPE_LATENCY = 2;

   // Colour of bar idx, counted from the left edge.
   function automatic logic [8:0] bar_colour(input logic [2:0] idx);
      logic [8:0] col;
      unique case (idx)
         3'd0:    col = COL_WHITE;
         3'd1:    col = COL_YELLOW;
         3'd2:    col = COL_CYAN;
         3'd3:    col = COL_GREEN;
         3'd4:    col = COL_MAGENTA;
         3'd5:    col = COL_RED;
         3'd6:    col = COL_BLUE;
         default: col = COL_BLACK;
      endcase
      return col;
   endfunction

endpackage

// File: rtl/vga_bounce_pos.sv
// One axis of the bouncing box: position and direction, updated once per tick.
module vga_bounce_pos #(
   parameter int unsigned LIMIT     = 640,
   parameter int unsigned BOX_SIZE  = 32,
   parameter int unsigned BOX_SPEED = 2
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_tick,
   output logic [9:0] o_pos
);

   // Widest legal top-left coordinate; compares are 11 bits so nothing wraps.
   localparam logic [10:0] POS_MAX = 11'(LIMIT - BOX_SIZE);
   localparam logic [10:0] SPEED   = 11'(BOX_SPEED);

   logic [9:0]  pos_q, pos_d;
   logic        dir_q, dir_d;  // 0 = increasing
   logic [10:0] pos_ext;

   assign pos_ext = {1'b0, pos_q};

   // Next position: step by SPEED, clamp at either wall and reverse.
   always_comb begin
      pos_d = pos_q;
      dir_d = dir_q;
      if (!dir_q) begin
         if (pos_ext + SPEED >= POS_MAX) begin
            pos_d = POS_MAX[9:0];
            dir_d = 1'b1;
         end else begin
            pos_d = pos_q + SPEED[9:0];
         end
      end else begin
         if (pos_ext <= SPEED) begin
            pos_d = '0;
            dir_d = 1'b0;
         end else begin
            pos_d = pos_q - SPEED[9:0];
         end
      end
   end

   // Position/direction register, advanced only on a frame tick.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pos_q <= '0;
         dir_q <= 1'b0;
      end else if (i_tick) begin
         pos_q <= pos_d;
         dir_q <= dir_d;
      end
   end

   assign o_pos = pos_q;

endmodule

// File: rtl/vga_test_pattern.sv
// VGA pixel-colour stage: background pattern plus bouncing box, 2-cycle pipeline.
module vga_test_pattern
   import vga_test_pattern_pkg::*;
#(
   parameter int unsigned H_ACTIVE_AREA = 640,
   parameter int unsigned V_ACTIVE_AREA = 480,
   parameter int unsigned BOX_SIZE      = 32,
   parameter int unsigned BOX_SPEED     = 2
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_hs,
   input  logic       i_vs,
   input  logic       i_activeArea,
   input  logic [9:0] i_px,
   input  logic [9:0] i_py,
   input  logic [1:0] i_pattern,
   output logic       o_hs,
   output logic       o_vs,
   output logic [2:0] o_red,
   output logic [2:0] o_grn,
   output logic [2:0] o_blu,
   output logic       o_frameTick
);

   localparam int unsigned BAR_W = H_ACTIVE_AREA / 8;

   logic        frame_tick;
   logic        tick_q;
   logic [7:0]  frame_cnt_q;
   pattern_e    pattern_q;
   logic [9:0]  box_x, box_y;

   logic [10:0] px_ext, py_ext, bx_ext, by_ext;
   logic        in_box;
   logic [2:0]  bar_idx;

   // Stage-1 registers.
   logic        act1_q, in_box1_q;
   logic [2:0]  bar_idx1_q, grad_b1_q;
   logic [8:0]  px1_q, py1_q;
   pattern_e    pat1_q;

   // Stage-2 registers and sync delay line.
   logic [8:0]              colour_d, colour_q;
   logic [PIPE_LATENCY-1:0] hs_dly_q, vs_dly_q;

   // Last visible pixel of the frame.
   assign frame_tick = i_activeArea && (i_px == 10'(H_ACTIVE_AREA - 1))
                       && (i_py == 10'(V_ACTIVE_AREA - 1));

   vga_bounce_pos #(
      .LIMIT     (H_ACTIVE_AREA),
      .BOX_SIZE  (BOX_SIZE),
      .BOX_SPEED (BOX_SPEED)
   ) u_bounce_x (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_tick  (frame_tick),
      .o_pos   (box_x)
   );

   vga_bounce_pos #(
      .LIMIT     (V_ACTIVE_AREA),
      .BOX_SIZE  (BOX_SIZE),
      .BOX_SPEED (BOX_SPEED)
   ) u_bounce_y (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_tick  (frame_tick),
      .o_pos   (box_y)
   );

   // Per-frame state: tick pulse, frame counter and tear-free pattern latch.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         tick_q      <= 1'b0;
         frame_cnt_q <= '0;
         pattern_q   <= PAT_BLACK;
      end else begin
         tick_q <= frame_tick;
         if (frame_tick) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
            pattern_q   <= pattern_e'(i_pattern);
         end
      end
   end

   assign px_ext = {1'b0, i_px};
   assign py_ext = {1'b0, i_py};
   assign bx_ext = {1'b0, box_x};
   assign by_ext = {1'b0, box_y};

   // Stage-1 combinational: box hit test and bar index by threshold compare.
   always_comb begin
      in_box = (px_ext >= bx_ext) && (px_ext < bx_ext + 11'(BOX_SIZE))
               && (py_ext >= by_ext) && (py_ext < by_ext + 11'(BOX_SIZE));
      bar_idx = '0;
      for (int k = 1; k < 8; k++) begin
         if (px_ext >= 11'(k * BAR_W)) begin
            bar_idx = 3'(k);
         end
      end
   end

   // Stage 1: capture pixel context; pattern/count are captured with the pixel so the
   // last pixel of a frame keeps that frame's settings.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         act1_q     <= 1'b0;
         in_box1_q  <= 1'b0;
         bar_idx1_q <= '0;
         grad_b1_q  <= '0;
         px1_q      <= '0;
         py1_q      <= '0;
         pat1_q     <= PAT_BLACK;
      end else begin
         act1_q     <= i_activeArea;
         in_box1_q  <= in_box;
         bar_idx1_q <= bar_idx;
         grad_b1_q  <= frame_cnt_q[5:3];
         px1_q      <= i_px[8:0];
         py1_q      <= i_py[8:0];
         pat1_q     <= pattern_q;
      end
   end

   // Stage-2 colour mux: blanking, then box, then background.
   always_comb begin
      colour_d = COL_BLACK;
      if (act1_q) begin
         if (in_box1_q && (pat1_q != PAT_GRAD)) begin
            colour_d = COL_WHITE;
         end else begin
            unique case (pat1_q)
               PAT_BLACK: colour_d = COL_BLACK;
               PAT_BARS:  colour_d = bar_colour(bar_idx1_q);
               PAT_CHECK: colour_d = (px1_q[5] ^ py1_q[5]) ? COL_WHITE : COL_BLACK;
               PAT_GRAD:  colour_d = {px1_q[8:6], py1_q[8:6], grad_b1_q};
               default:   colour_d = COL_BLACK;
            endcase
         end
      end
   end

   // Stage 2: colour register and matching sync delay.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         colour_q <= '0;
         hs_dly_q <= '0;
         vs_dly_q <= '0;
      end else begin
         colour_q <= colour_d;
         hs_dly_q <= {hs_dly_q[PIPE_LATENCY-2:0], i_hs};
         vs_dly_q <= {vs_dly_q[PIPE_LATENCY-2:0], i_vs};
      end
   end

   assign o_hs        = hs_dly_q[PIPE_LATENCY-1];
   assign o_vs        = vs_dly_q[PIPE_LATENCY-1];
   assign o_red       = colour_q[8:6];
   assign o_grn       = colour_q[5:3];
   assign o_blu       = colour_q[2:0];
   assign o_frameTick = tick_q;

endmodule

// File: tb/tb_vga_test_pattern.sv
// Directed bench for vga_test_pattern: vector table plus hand-written frame sequences.
module tb_vga_test_pattern;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       hs = 1'b0, vs = 1'b0, act = 1'b0;
   logic [9:0] px = '0, py = '0;
   logic [1:0] pat = '0;
   logic       o_hs, o_vs, o_tick;
   logic [2:0] o_red, o_grn, o_blu;

   // Stand-alone axis with an odd wall (max = 41-32 = 9) to reach x=1 moving left.
   logic       lt_tick = 1'b0;
   logic [9:0] lt_pos;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vga_test_pattern #(
      .H_ACTIVE_AREA (640),
      .V_ACTIVE_AREA (480),
      .BOX_SIZE      (32),
      .BOX_SPEED     (2)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_hs         (hs),
      .i_vs         (vs),
      .i_activeArea (act),
      .i_px         (px),
      .i_py         (py),
      .i_pattern    (pat),
      .o_hs         (o_hs),
      .o_vs         (o_vs),
      .o_red        (o_red),
      .o_grn        (o_grn),
      .o_blu        (o_blu),
      .o_frameTick  (o_tick)
   );

   vga_bounce_pos #(
      .LIMIT     (41),
      .BOX_SIZE  (32),
      .BOX_SPEED (2)
   ) u_lt (
      .i_clk   (clk),
      .i_reset (rst),
      .i_tick  (lt_tick),
      .o_pos   (lt_pos)
   );

   typedef struct {
      logic       tick;  // issue a frame tick (latching pat) before the probe
      logic [1:0] pat;
      logic       act;
      int         x;
      int         y;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Present one pixel, wait out the 2-cycle pipeline and compare packed RGB.
   task automatic probe(input string name, input logic a, input int x, input int y,
                        input logic [8:0] exp);
      act = a;
      px  = 10'(x);
      py  = 10'(y);
      step();
      step();
      check(name, {23'd0, o_red, o_grn, o_blu}, {23'd0, exp});
      act = 1'b0;
   endtask

   task automatic do_ticks(input int n, input logic [1:0] p);
      pat = p;
      repeat (n) begin
         act = 1'b1;
         px  = 10'd639;
         py  = 10'd479;
         step();
      end
      act = 1'b0;
      px  = '0;
      py  = '0;
   endtask

   // Box edges seen through pattern 0 (black background, white box).
   task automatic check_box(input int x, input int y);
      probe($sformatf("box_tl(%0d,%0d)", x, y), 1'b1, x, y, 9'o777);
      probe($sformatf("box_tr(%0d,%0d)", x, y), 1'b1, x + 31, y, 9'o777);
      probe($sformatf("box_bl(%0d,%0d)", x, y), 1'b1, x, y + 31, 9'o777);
      if (x > 0)        probe($sformatf("box_l(%0d,%0d)", x, y), 1'b1, x - 1, y, 9'o000);
      if (y > 0)        probe($sformatf("box_t(%0d,%0d)", x, y), 1'b1, x, y - 1, 9'o000);
      if (x + 32 < 640) probe($sformatf("box_r(%0d,%0d)", x, y), 1'b1, x + 32, y, 9'o000);
      if (y + 32 < 480) probe($sformatf("box_b(%0d,%0d)", x, y), 1'b1, x, y + 32, 9'o000);
   endtask

   initial begin
      int lt_exp [11];
      lt_exp = '{2, 4, 6, 8, 9, 7, 5, 3, 1, 0, 2};

      // Box at (0,0), pattern register 0 after reset.
      tbl.push_back('{1'b0, 2'd0, 1'b1,   5,   5, 9'o777});
      tbl.push_back('{1'b0, 2'd0, 1'b1,  40,   5, 9'o000});
      tbl.push_back('{1'b0, 2'd0, 1'b1,  31,  31, 9'o777});
      tbl.push_back('{1'b0, 2'd0, 1'b1,  32,   0, 9'o000});
      tbl.push_back('{1'b0, 2'd0, 1'b1,   0,  32, 9'o000});
      tbl.push_back('{1'b0, 2'd0, 1'b0,   5,   5, 9'o000});
      // Tick into colour bars; box now (2,2), rows 200 are clear of it.
      tbl.push_back('{1'b1, 2'd1, 1'b1,   0, 200, 9'o777});
      tbl.push_back('{1'b0, 2'd1, 1'b1,  79, 200, 9'o777});
      tbl.push_back('{1'b0, 2'd1, 1'b1,  80, 200, 9'o770});
      tbl.push_back('{1'b0, 2'd1, 1'b1, 160, 200, 9'o077});
      tbl.push_back('{1'b0, 2'd1, 1'b1, 240, 200, 9'o070});
      tbl.push_back('{1'b0, 2'd1, 1'b1, 320, 200, 9'o707});
      tbl.push_back('{1'b0, 2'd1, 1'b1, 400, 200, 9'o700});
      tbl.push_back('{1'b0, 2'd1, 1'b1, 480, 200, 9'o007});
      tbl.push_back('{1'b0, 2'd1, 1'b1, 560, 200, 9'o000});
      tbl.push_back('{1'b0, 2'd1, 1'b1, 639, 200, 9'o000});
      tbl.push_back('{1'b0, 2'd1, 1'b0,  80, 200, 9'o000});
      // i_pattern changes mid-frame: still bars (yellow at px=100).
      tbl.push_back('{1'b0, 2'd2, 1'b1, 100, 100, 9'o770});
      // Tick into checkerboard; box now (4,4).
      tbl.push_back('{1'b1, 2'd2, 1'b1,  32,   0, 9'o777});
      tbl.push_back('{1'b0, 2'd2, 1'b1, 100, 100, 9'o000});
      tbl.push_back('{1'b0, 2'd2, 1'b1,  64,  32, 9'o777});
      tbl.push_back('{1'b0, 2'd2, 1'b1,  64,  64, 9'o000});
      tbl.push_back('{1'b0, 2'd2, 1'b1,  32,  40, 9'o000});
      tbl.push_back('{1'b0, 2'd2, 1'b1,   5,   6, 9'o777});
      tbl.push_back('{1'b0, 2'd2, 1'b1,   3,   6, 9'o000});
      tbl.push_back('{1'b0, 2'd2, 1'b1,  35,  35, 9'o777});
      tbl.push_back('{1'b0, 2'd2, 1'b1,  36,  35, 9'o000});
      tbl.push_back('{1'b0, 2'd2, 1'b1,  35,  36, 9'o000});
      // Tick into gradient; box (6,6) hidden, frame count 3 -> blu 0.
      tbl.push_back('{1'b1, 2'd3, 1'b1,   7,   7, 9'o000});
      tbl.push_back('{1'b0, 2'd3, 1'b1, 200, 300, 9'o340});
      tbl.push_back('{1'b0, 2'd3, 1'b1, 511, 450, 9'o770});
      tbl.push_back('{1'b0, 2'd3, 1'b0, 200, 300, 9'o000});

      // Reset holds every output low even with sync and pixels driven.
      hs  = 1'b1;
      vs  = 1'b1;
      act = 1'b1;
      px  = 10'd5;
      py  = 10'd5;
      pat = 2'd1;
      step();
      step();
      check("rst_hs", {31'd0, o_hs}, 32'd0);
      check("rst_vs", {31'd0, o_vs}, 32'd0);
      check("rst_rgb", {23'd0, o_red, o_grn, o_blu}, 32'd0);
      check("rst_tick", {31'd0, o_tick}, 32'd0);
      check("rst_lt_pos", {22'd0, lt_pos}, 32'd0);
      hs  = 1'b0;
      vs  = 1'b0;
      act = 1'b0;
      pat = 2'd0;
      rst = 1'b0;
      step();
      step();

      // One-cycle hs pulse reappears exactly two cycles later.
      hs = 1'b1;
      step();
      hs = 1'b0;
      check("hs_n1", {31'd0, o_hs}, 32'd0);
      step();
      check("hs_n2", {31'd0, o_hs}, 32'd1);
      step();
      check("hs_n3", {31'd0, o_hs}, 32'd0);

      // Left-wall bounce on the odd-limit axis: ... 9, 7, 5, 3, 1 -> 0 -> 2.
      for (int i = 0; i < 11; i++) begin
         lt_tick = 1'b1;
         step();
         lt_tick = 1'b0;
         if (i == 4 || i >= 8) check($sformatf("lt_pos%0d", i), {22'd0, lt_pos}, lt_exp[i]);
      end

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].tick) do_ticks(1, tbl[i].pat);
         pat = tbl[i].pat;
         probe($sformatf("vec%0d", i), tbl[i].act, tbl[i].x, tbl[i].y, tbl[i].exp);
      end
      // Three ticks so far.

      // Tick pulse lands one cycle after the last pixel and lasts one cycle.
      act = 1'b1;
      px  = 10'd639;
      py  = 10'd479;
      step();
      act = 1'b0;
      check("tick_n1", {31'd0, o_tick}, 32'd1);
      step();
      check("tick_n2", {31'd0, o_tick}, 32'd0);
      // Same coordinates outside the active area must not tick.
      step();
      check("tick_blank", {31'd0, o_tick}, 32'd0);
      // Four ticks so far.

      do_ticks(4, 2'd3);
      probe("fc8", 1'b1, 64, 128, 9'o121);
      do_ticks(216, 2'd0);
      check_box(448, 448);  // 224 ticks: y at bottom wall
      do_ticks(1, 2'd0);
      check_box(450, 446);  // y reversed
      do_ticks(30, 2'd3);
      probe("fc255", 1'b1, 64, 128, 9'o127);
      do_ticks(1, 2'd3);
      probe("fc_wrap", 1'b1, 64, 128, 9'o120);
      do_ticks(48, 2'd0);
      check_box(608, 288);  // 304 ticks: x at right wall
      do_ticks(1, 2'd0);
      check_box(606, 286);

      // Asynchronous reset mid-frame clears the outputs without a clock edge.
      act = 1'b1;
      px  = 10'd606;
      py  = 10'd286;
      step();
      step();
      #2 rst = 1'b1;
      #1 check("async_rst_rgb", {23'd0, o_red, o_grn, o_blu}, 32'd0);
      act = 1'b0;
      step();
      rst = 1'b0;
      step();
      check_box(0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
